// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction timer controller.
//   state_t    - FSM state encoding, also driven out on the State port
//   BCD_MAX    - counter value 9,9,9 at which a trial times out
//   LFSR_TAPS  - Galois feedback mask for taps 16,14,13,11
//   DELAY_W    - width of the random wait counter
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ARMED = 3'd2,
    S_DONE  = 3'd3,
    S_EARLY = 3'd4,
    S_TMO   = 3'd5
  } state_t;

  localparam int unsigned DELAY_W   = 12;
  localparam logic [11:0] BCD_MAX   = 12'h999;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// reaction_timer_ctrl_if: link between the controller and the external BCD counter.
//   BCD0/BCD1/BCD2 - counter digits (ones/tens/hundreds), counter -> controller
//   Cnt_En         - increment enable, controller -> counter
//   Cnt_Clr_n      - active-low synchronous clear, controller -> counter
//   modport master : controller side; modport slave : counter side
interface reaction_timer_ctrl_if;

  logic [3:0] BCD0;
  logic [3:0] BCD1;
  logic [3:0] BCD2;
  logic       Cnt_En;
  logic       Cnt_Clr_n;

  modport master (
    input  BCD0, BCD1, BCD2,
    output Cnt_En, Cnt_Clr_n
  );

  modport slave (
    output BCD0, BCD1, BCD2,
    input  Cnt_En, Cnt_Clr_n
  );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (taps 16,14,13,11), steps every clock.
//   Clock - system clock
//   Clear - asynchronous active-high reset, loads SEED
//   q     - current LFSR state
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Clear,
  output logic [15:0] q
);

  // Right-shifting Galois form: feedback bit is the outgoing LSB.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      q <= SEED;
    end else begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: reaction-time game controller.
//   Clock, Clear          - clock and asynchronous active-high reset
//   Start, React, Tick_ms - trial start pulse, button pulse, 1 ms tick pulse
//   cnt (master)          - BCD counter link: digits in, Cnt_En/Cnt_Clr_n out (combinational)
//   Led                   - stimulus lamp, high while ARMED
//   Done, Early, Timeout  - trial result flags
//   Best0/Best1/Best2     - best reaction time so far in BCD
//   State                 - current FSM state code
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Start,
  input  logic                  React,
  input  logic                  Tick_ms,
  reaction_timer_ctrl_if.master cnt,
  output logic                  Led,
  output logic                  Done,
  output logic                  Early,
  output logic                  Timeout,
  output logic [3:0]            Best0,
  output logic [3:0]            Best1,
  output logic [3:0]            Best2,
  output logic [2:0]            State
);

  state_t             state;
  state_t             state_nx;
  logic [DELAY_W-1:0] delay;
  logic [11:0]        best;
  logic [11:0]        bcd;
  logic [15:0]        lfsr_q;
  logic [5:0]         unused_lfsr_hi;
  logic               start_ok;
  logic               at_max;
  logic               cnt_en;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock (Clock),
    .Clear (Clear),
    .q     (lfsr_q)
  );

  // Only the low ten bits feed the random wait.
  assign unused_lfsr_hi = lfsr_q[15:10];

  assign bcd    = {cnt.BCD2, cnt.BCD1, cnt.BCD0};
  assign at_max = (bcd == BCD_MAX);

  // Start is honoured from every resting state; WAIT and ARMED ignore it.
  assign start_ok = Start && (state == S_IDLE || state == S_DONE ||
                              state == S_EARLY || state == S_TMO);

  // Next-state decode and counter enable.
  always_comb begin
    state_nx = state;
    cnt_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (React)                                   state_nx = S_EARLY;
        else if (Tick_ms && delay == DELAY_W'(1))    state_nx = S_ARMED;
      end
      S_ARMED: begin
        // Enable is withheld at 9,9,9 so the counter never wraps.
        cnt_en = Tick_ms && !React && !at_max;
        if (React)                 state_nx = S_DONE;
        else if (Tick_ms && at_max) state_nx = S_TMO;
      end
      S_DONE, S_EARLY, S_TMO: begin
        if (Start) state_nx = S_WAIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cnt.Cnt_En    = cnt_en;
  assign cnt.Cnt_Clr_n = ~start_ok;

  // State register, registered flags, random wait counter and best time.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state   <= S_IDLE;
      Led     <= 1'b0;
      Done    <= 1'b0;
      Early   <= 1'b0;
      Timeout <= 1'b0;
      delay   <= '0;
      best    <= BCD_MAX;
    end else begin
      state   <= state_nx;
      Led     <= (state_nx == S_ARMED);
      Done    <= (state_nx == S_DONE);
      Early   <= (state_nx == S_EARLY);
      Timeout <= (state_nx == S_TMO);

      if (start_ok) begin
        delay <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[9:0]);
      end else if (state == S_WAIT && Tick_ms && !React && delay != '0) begin
        delay <= delay - DELAY_W'(1);
      end

      // BCD digits compare correctly as a plain binary number.
      if (state == S_ARMED && React && bcd < best) begin
        best <= bcd;
      end
    end
  end

  assign {Best2, Best1, Best0} = best;
  assign State                 = state;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: directed bench for reaction_timer_ctrl with a BCD
// counter and an independent LFSR reference alongside the design.
`timescale 1ns/1ps
module tb_reaction_timer_ctrl;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Start;
  logic        React;
  logic        Tick_ms;
  logic        Led, Done, Early, Timeout;
  logic [3:0]  Best0, Best1, Best2;
  logic [2:0]  State;

  logic [15:0] m_lfsr;
  logic        c_clr_n;
  logic        c_en;
  int          n_total = 0;
  int          n_pass  = 0;

  reaction_timer_ctrl_if bus ();

  reaction_timer_ctrl dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Start   (Start),
    .React   (React),
    .Tick_ms (Tick_ms),
    .cnt     (bus),
    .Led     (Led),
    .Done    (Done),
    .Early   (Early),
    .Timeout (Timeout),
    .Best0   (Best0),
    .Best1   (Best1),
    .Best2   (Best2),
    .State   (State)
  );

  always #5 Clock = ~Clock;

  // External BCD counter driven by the controller.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      bus.BCD0 <= 4'd0;
      bus.BCD1 <= 4'd0;
      bus.BCD2 <= 4'd0;
    end else if (!bus.Cnt_Clr_n) begin
      bus.BCD0 <= 4'd0;
      bus.BCD1 <= 4'd0;
      bus.BCD2 <= 4'd0;
    end else if (bus.Cnt_En) begin
      if (bus.BCD0 == 4'd9) begin
        bus.BCD0 <= 4'd0;
        if (bus.BCD1 == 4'd9) begin
          bus.BCD1 <= 4'd0;
          bus.BCD2 <= bus.BCD2 + 4'd1;
        end else begin
          bus.BCD1 <= bus.BCD1 + 4'd1;
        end
      end else begin
        bus.BCD0 <= bus.BCD0 + 4'd1;
      end
    end
  end

  // Reference LFSR: bit 15 is tap 16, so taps 16,14,13,11 give mask 1011_0100_0000_0000.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'b1011_0100_0000_0000 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // One clock cycle: drive inputs, capture combinational outputs, sample #1 after the edge.
  task automatic cyc(input logic s, input logic r, input logic t);
    Start   = s;
    React   = r;
    Tick_ms = t;
    #2;
    c_clr_n = bus.Cnt_Clr_n;
    c_en    = bus.Cnt_En;
    @(posedge Clock);
    #1;
    Start   = 1'b0;
    React   = 1'b0;
    Tick_ms = 1'b0;
  endtask

  function automatic logic [31:0] bcd_now();
    return 32'({bus.BCD2, bus.BCD1, bus.BCD0});
  endfunction

  function automatic logic [31:0] best_now();
    return 32'({Best2, Best1, Best0});
  endfunction

  // Tick through a known wait; lamp and enable must stay low until the last tick.
  task automatic wait_armed(input int n);
    logic led_seen = 1'b0;
    logic en_seen  = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (Led)  led_seen = 1'b1;
      if (c_en) en_seen  = 1'b1;
    end
    check("wait_led_low", 32'(led_seen), 32'd0);
    check("wait_en_low", 32'(en_seen), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    check("led_rise", 32'(Led), 32'd1);
    check("armed_state", 32'(State), 32'd2);
  endtask

  // Start a trial from a resting state and run it up to ARMED.
  task automatic arm();
    int d;
    d = 1000 + int'(m_lfsr[9:0]);
    cyc(1'b1, 1'b0, 1'b0);
    check("start_clr_n", 32'(c_clr_n), 32'd0);
    check("start_state", 32'(State), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("after_start_clr_n", 32'(c_clr_n), 32'd1);
    wait_armed(d);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d;
    Clear   = 1'b1;
    Start   = 1'b0;
    React   = 1'b0;
    Tick_ms = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_flags", 32'({Led, Done, Early, Timeout}), 32'd0);
    check("rst_best", best_now(), 32'h999);
    check("rst_clr_n", 32'(bus.Cnt_Clr_n), 32'd1);
    Clear = 1'b0;
    #2;

    // React in IDLE is ignored.
    cyc(1'b0, 1'b1, 1'b1);
    check("idle_react", 32'(State), 32'd0);

    // Trial 1: 237 ms.
    arm();
    ticks(237);
    check("t1_bcd", bcd_now(), 32'h237);
    cyc(1'b0, 1'b1, 1'b0);
    check("t1_state", 32'(State), 32'd3);
    check("t1_flags", 32'({Led, Done, Early, Timeout}), 32'b0100);
    check("t1_best", best_now(), 32'h237);
    cyc(1'b0, 1'b1, 1'b0);
    check("done_react_ign", 32'(State), 32'd3);

    // Trial 2: 250 ms does not beat 237.
    arm();
    ticks(250);
    cyc(1'b0, 1'b1, 1'b0);
    check("t2_bcd", bcd_now(), 32'h250);
    check("t2_best", best_now(), 32'h237);

    // Early press during WAIT, together with a tick.
    cyc(1'b1, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b1, 1'b1);
    check("early_en", 32'(c_en), 32'd0);
    check("early_state", 32'(State), 32'd4);
    check("early_flags", 32'({Led, Done, Early, Timeout}), 32'b0010);
    cyc(1'b0, 1'b1, 1'b0);
    check("early_react_ign", 32'(State), 32'd4);
    d = 1000 + int'(m_lfsr[9:0]);
    cyc(1'b1, 1'b0, 1'b0);
    check("early_restart_clr_n", 32'(c_clr_n), 32'd0);
    check("early_restart", 32'(State), 32'd1);
    check("early_cleared", 32'(Early), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("wait_start_ign_clr_n", 32'(c_clr_n), 32'd1);
    check("wait_start_ign", 32'(State), 32'd1);
    wait_armed(d);

    // Timeout: 999 ticks reach 9,9,9, the next one times out without wrapping.
    ticks(999);
    check("tmo_pre_bcd", bcd_now(), 32'h999);
    check("tmo_pre_state", 32'(State), 32'd2);
    cyc(1'b0, 1'b0, 1'b1);
    check("tmo_en", 32'(c_en), 32'd0);
    check("tmo_state", 32'(State), 32'd5);
    check("tmo_flags", 32'({Led, Done, Early, Timeout}), 32'b0001);
    cyc(1'b0, 1'b0, 1'b1);
    check("tmo_bcd_hold", bcd_now(), 32'h999);
    check("tmo_best", best_now(), 32'h237);

    // React and tick together while ARMED: no increment on that edge.
    arm();
    ticks(5);
    cyc(1'b0, 1'b1, 1'b1);
    check("rt_en", 32'(c_en), 32'd0);
    check("rt_state", 32'(State), 32'd3);
    check("rt_bcd", bcd_now(), 32'h005);
    check("rt_best", best_now(), 32'h005);

    // Clear mid-ARMED acts immediately, without a clock edge.
    arm();
    ticks(10);
    Clear = 1'b1;
    #1;
    check("clr_state", 32'(State), 32'd0);
    check("clr_led", 32'(Led), 32'd0);
    check("clr_best", best_now(), 32'h999);
    check("clr_clr_n", 32'(bus.Cnt_Clr_n), 32'd1);
    #1;
    Clear = 1'b0;
    @(posedge Clock);
    #1;

    // First Start after Clear, with a simultaneous React, behaves as from IDLE.
    d = 1000 + int'(m_lfsr[9:0]);
    cyc(1'b1, 1'b1, 1'b0);
    check("post_clr_clr_n", 32'(c_clr_n), 32'd0);
    check("post_clr_state", 32'(State), 32'd1);
    wait_armed(d);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
